// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler and its refresh timer.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } sched_state_t;

  localparam int GUARD_CYCLES = 2;
  localparam int DEF_CH_NUM   = 8;
  localparam int DEF_TMR_W    = 24;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/frame_sched_if.sv
// Host/channel-facing signal bundle of the frame scheduler.
interface frame_sched_if
  import frame_sched_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int TMR_W  = DEF_TMR_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              frame_rdy_in;
  logic [CH_NUM-1:0] ch_en_in;
  logic [CH_NUM-1:0] ch_busy_in;
  logic              refresh_en_in;
  logic [TMR_W-1:0]  refresh_period_in;
  logic [TMR_W-1:0]  timeout_in;
  logic [CH_NUM-1:0] ch_start_out;
  logic              busy_out;
  logic              frame_done_out;
  logic              frame_drop_out;
  logic              timeout_out;
  logic [CNT_W-1:0]  frame_cnt_out;

  modport master (
    output frame_rdy_in, ch_en_in, ch_busy_in, refresh_en_in, refresh_period_in, timeout_in,
    input  ch_start_out, busy_out, frame_done_out, frame_drop_out, timeout_out, frame_cnt_out
  );

  modport slave (
    input  frame_rdy_in, ch_en_in, ch_busy_in, refresh_en_in, refresh_period_in, timeout_in,
    output ch_start_out, busy_out, frame_done_out, frame_drop_out, timeout_out, frame_cnt_out
  );

endinterface

// File: rtl/frame_sched_refresh_timer.sv
// Free-running auto-refresh counter; ticks when it reaches period-1, then restarts.
module refresh_timer #(
  parameter int TMR_W = 24
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_refreshEn,
  input  logic [TMR_W-1:0] i_period,
  input  logic             i_clear,
  output logic             o_tick
);

  logic [TMR_W-1:0] r_count;

  // Equality compare only, so a period shrunk below the count wraps through max.
  assign o_tick = i_refreshEn && (i_period != '0) && (r_count == i_period - 1'b1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (o_tick || i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: turns host commits and auto-refresh ticks into per-channel
// start pulses, tracks completion, queues one frame and watches for stuck channels.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int TMR_W  = DEF_TMR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  frame_sched_if.slave bus
);

  sched_state_t      r_state, w_nextState;
  logic [CH_NUM-1:0] r_mask, w_nextMask;
  logic              r_pending, w_nextPending;
  logic [1:0]        r_guard, w_nextGuard;
  logic [TMR_W-1:0]  r_wdog, w_nextWdog;
  logic [CH_NUM-1:0] r_chStart, w_chStart;
  logic              r_busy, r_done, r_drop, r_timeout;
  logic              w_done, w_drop, w_timeout;
  logic [CNT_W-1:0]  r_frameCnt;
  logic              w_clearTimer, w_refreshTick;

  refresh_timer #(.TMR_W(TMR_W)) u_refreshTimer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_refreshEn (bus.refresh_en_in),
    .i_period    (bus.refresh_period_in),
    .i_clear     (w_clearTimer),
    .o_tick      (w_refreshTick)
  );

  always_comb begin
    w_nextState   = r_state;
    w_nextMask    = r_mask;
    w_nextPending = r_pending;
    w_nextGuard   = r_guard;
    w_nextWdog    = r_wdog;
    w_chStart     = '0;
    w_done        = 1'b0;
    w_drop        = 1'b0;
    w_timeout     = 1'b0;
    w_clearTimer  = 1'b0;

    if (r_state != IDLE && bus.frame_rdy_in) begin
      if (r_pending) w_drop = 1'b1;
      else           w_nextPending = 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        if (r_pending || bus.frame_rdy_in || w_refreshTick) begin
          // A commit arriving while the queued frame launches becomes the new queued frame.
          w_nextPending = r_pending & bus.frame_rdy_in;
          w_nextMask    = bus.ch_en_in;
          w_chStart     = bus.ch_en_in;
          w_clearTimer  = 1'b1;
          w_nextState   = START;
        end
      end
      START: begin
        if (r_mask == '0) begin
          w_done      = 1'b1;
          w_nextState = DONE;
        end else begin
          w_nextGuard = 2'(GUARD_CYCLES);
          w_nextWdog  = '0;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (r_guard != '0) w_nextGuard = r_guard - 1'b1;
        if (r_wdog != '1)  w_nextWdog  = r_wdog + 1'b1;
        // Busy is only trusted once the guard has covered the serializers' rise latency.
        if (r_guard == '0 && (bus.ch_busy_in & r_mask) == '0) begin
          w_done      = 1'b1;
          w_nextState = DONE;
        end else if (bus.timeout_in != '0 && r_wdog == bus.timeout_in - 1'b1) begin
          w_timeout   = 1'b1;
          w_done      = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_pending  <= 1'b0;
      r_guard    <= '0;
      r_wdog     <= '0;
      r_chStart  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_timeout  <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_mask     <= w_nextMask;
      r_pending  <= w_nextPending;
      r_guard    <= w_nextGuard;
      r_wdog     <= w_nextWdog;
      r_chStart  <= w_chStart;
      r_busy     <= (w_nextState != IDLE);
      r_done     <= w_done;
      r_drop     <= w_drop;
      r_timeout  <= w_timeout;
      if (w_done) r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  assign bus.ch_start_out   = r_chStart;
  assign bus.busy_out       = r_busy;
  assign bus.frame_done_out = r_done;
  assign bus.frame_drop_out = r_drop;
  assign bus.timeout_out    = r_timeout;
  assign bus.frame_cnt_out  = r_frameCnt;

endmodule

// File: tb/tb_frame_sched.sv
// Randomized bench for frame_sched, checked every cycle against a timestamp-based
// reference model of the scheduler's frame lifecycle.
module tb_frame_sched;

  localparam int CH    = 8;
  localparam int TW    = 24;
  localparam int CW    = 16;
  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  frame_sched_if #(.CH_NUM(CH), .TMR_W(TW), .CNT_W(CW)) bus ();

  frame_sched #(.CH_NUM(CH), .TMR_W(TW), .CNT_W(CW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stimulus knobs
  bit forceRdy  = 1'b0;
  bit forceRst  = 1'b0;
  bit stuck3    = 1'b0;
  bit enRandom  = 1'b0;
  int rdyPct    = 0;
  int rstPct    = 0;
  int lenMin    = 0;
  int lenMax    = 0;
  int busyLeft[CH];

  // Reference model: a frame is described by the cycle it starts and the cycle it ends
  bit          mActive  = 1'b0;
  bit          mPending = 1'b0;
  int          mStartAt = -1;
  int          mDoneAt  = -1;
  int          cyc      = 0;
  logic [CH-1:0] mMask  = '0;
  logic [TW-1:0] mTimer = '0;
  logic [CW-1:0] mCount = '0;
  logic [CH-1:0] eStart = '0;
  bit          eBusy, eDone, eDrop, eTmo;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic closeFrame(input bit byTimeout);
    mDoneAt = cyc + 1;
    eDone   = 1'b1;
    eTmo    = byTimeout;
    mCount  = mCount + 1'b1;
  endtask

  task automatic modelStep();
    logic [TW-1:0] pm1;
    bit tick;
    bit startNow;
    int runAge;
    eStart = '0; eDone = 1'b0; eDrop = 1'b0; eTmo = 1'b0; startNow = 1'b0;
    if (rst) begin
      mActive = 1'b0; mPending = 1'b0; mTimer = '0; mCount = '0; mMask = '0;
      eBusy = 1'b0; mStartAt = -1; mDoneAt = -1;
      cyc++;
      return;
    end
    pm1  = bus.refresh_period_in - 1'b1;
    tick = bus.refresh_en_in && (bus.refresh_period_in != '0) && (mTimer == pm1);
    if (!mActive) begin
      if (mPending || bus.frame_rdy_in || tick) begin
        startNow = 1'b1;
        mActive  = 1'b1;
        mStartAt = cyc + 1;
        mDoneAt  = -1;
        mMask    = bus.ch_en_in;
        eStart   = bus.ch_en_in;
        mPending = mPending && bus.frame_rdy_in;
      end
    end else begin
      if (bus.frame_rdy_in) begin
        if (mPending) eDrop = 1'b1;
        else          mPending = 1'b1;
      end
      if (cyc == mDoneAt) begin
        mActive = 1'b0;
      end else if (cyc == mStartAt) begin
        if (mMask == '0) closeFrame(1'b0);
      end else begin
        runAge = cyc - mStartAt - 1;
        if (runAge >= GUARD && (bus.ch_busy_in & mMask) == '0) closeFrame(1'b0);
        else if (bus.timeout_in != '0 && runAge == int'(bus.timeout_in) - 1) closeFrame(1'b1);
      end
    end
    mTimer = (tick || startNow) ? '0 : mTimer + 1'b1;
    eBusy  = mActive;
    cyc++;
  endtask

  // Busy emulates a serializer: high from the cycle after its start pulse for a random length
  task automatic applyStimulus();
    logic [CH-1:0] busy;
    for (int i = 0; i < CH; i++) begin
      busy[i] = (busyLeft[i] > 0);
      if (busyLeft[i] > 0) busyLeft[i]--;
      if (bus.ch_start_out[i] === 1'b1) busyLeft[i] = int'($urandom_range(lenMax, lenMin));
    end
    if (stuck3) busy[3] = 1'b1;
    bus.ch_busy_in   = busy;
    bus.frame_rdy_in = forceRdy || (rdyPct > 0 && int'($urandom_range(99, 0)) < rdyPct);
    rst              = forceRst || (rstPct > 0 && int'($urandom_range(99, 0)) < rstPct);
    if (enRandom) bus.ch_en_in = CH'($urandom);
    forceRdy = 1'b0;
    forceRst = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("ch_start", 32'(bus.ch_start_out), 32'(eStart));
    checkOutput("busy", 32'(bus.busy_out), 32'(eBusy));
    checkOutput("done", 32'(bus.frame_done_out), 32'(eDone));
    checkOutput("drop", 32'(bus.frame_drop_out), 32'(eDrop));
    checkOutput("timeout", 32'(bus.timeout_out), 32'(eTmo));
    checkOutput("frame_cnt", 32'(bus.frame_cnt_out), 32'(mCount));
    applyStimulus();
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  initial begin
    for (int i = 0; i < CH; i++) busyLeft[i] = 0;
    rst                   = 1'b1;
    bus.frame_rdy_in      = 1'b0;
    bus.ch_en_in          = 8'hFF;
    bus.ch_busy_in        = '0;
    bus.refresh_en_in     = 1'b0;
    bus.refresh_period_in = '0;
    bus.timeout_in        = '0;

    forceRst = 1'b1;
    runCycles(1);
    forceRst = 1'b1;
    runCycles(2);

    $display("[TB] basic frame");
    lenMin = 39; lenMax = 39;
    forceRdy = 1'b1;
    runCycles(60);

    $display("[TB] queue and drop");
    forceRdy = 1'b1; runCycles(10);
    forceRdy = 1'b1; runCycles(5);
    forceRdy = 1'b1; runCycles(5);
    forceRdy = 1'b1; runCycles(120);

    $display("[TB] auto refresh");
    bus.ch_en_in = 8'h03; lenMin = 0; lenMax = 0;
    bus.refresh_period_in = 24'd100; bus.refresh_en_in = 1'b1;
    runCycles(50);
    forceRdy = 1'b1;
    runCycles(300);
    bus.refresh_en_in = 1'b0;
    runCycles(10);

    $display("[TB] watchdog");
    bus.ch_en_in = 8'hFF; lenMin = 5; lenMax = 5; stuck3 = 1'b1;
    bus.timeout_in = 24'd500;
    forceRdy = 1'b1;
    runCycles(520);
    stuck3 = 1'b0; bus.timeout_in = '0;
    runCycles(5);

    $display("[TB] empty mask");
    bus.ch_en_in = '0;
    forceRdy = 1'b1;
    runCycles(10);

    $display("[TB] reset mid-run");
    bus.ch_en_in = 8'hFF; lenMin = 30; lenMax = 30;
    forceRdy = 1'b1; runCycles(10);
    forceRdy = 1'b1; runCycles(3);
    forceRst = 1'b1; runCycles(3);
    forceRdy = 1'b1; runCycles(50);

    $display("[TB] random traffic");
    for (int seg = 0; seg < 40; seg++) begin
      bus.ch_en_in          = CH'($urandom);
      enRandom              = ($urandom_range(3, 0) == 0);
      bus.refresh_en_in     = $urandom_range(1, 0) == 1;
      bus.refresh_period_in = TW'($urandom_range(40, 0));
      bus.timeout_in        = TW'($urandom_range(60, 0));
      rdyPct                = int'($urandom_range(20, 0));
      rstPct                = ($urandom_range(4, 0) == 0) ? 1 : 0;
      lenMin                = 0;
      lenMax                = int'($urandom_range(50, 0));
      stuck3                = ($urandom_range(7, 0) == 0);
      runCycles(100);
    end
    enRandom = 1'b0; rdyPct = 0; rstPct = 0; stuck3 = 1'b0;
    runCycles(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
